// File: rtl/program_loader.sv
// Byte-stream program loader: pairs big-endian bytes into 16-bit words
// and writes them to instruction memory from address 0 until END_WORD.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] END_WORD  = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] instruct_dir,
  output logic              we,
  output logic              finish,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              xfer;
  logic [15:0]       word;
  logic [ADDR_W:0]   count_inc;

  assign byte_ready = (state_q == HI) || (state_q == LO);
  assign xfer       = byte_valid && byte_ready;
  assign word       = {hi_byte_q, byte_data};
  assign count_inc  = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    instr_d   = instr_q;
    dir_d     = dir_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HI;
          dir_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      HI: begin
        if (xfer) begin
          hi_byte_d = byte_data;
          state_d   = LO;
        end
      end
      LO: begin
        if (xfer) begin
          if (word == END_WORD) begin
            state_d = DONE;
          end else begin
            instr_d = word;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        count_d = count_inc;
        // Capacity reached: stop here so the address never wraps.
        if (count_inc == MAX_CNT) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          dir_d   = dir_q + ADDR_W'(1);
          state_d = HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_byte_q <= '0;
      instr_q   <= '0;
      dir_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      instr_q   <= instr_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign instruction  = instr_q;
  assign instruct_dir = dir_q;
  assign we           = (state_q == WRITE);
  assign finish       = (state_q == DONE);
  assign busy         = byte_ready || (state_q == WRITE);
  assign word_count   = count_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the 16-bit processor's instruction memory.
- Receives a byte stream through a valid/ready handshake and assembles big-endian 16-bit instructions.
- Writes each instruction at sequential addresses from 0 by driving instruction, instruct_dir and a one-cycle we strobe.
- Raises finish when the stream ends, so the processor leaves load mode and starts executing from address 0.

Parameters:
- ADDR_W, 8: instruction address width (instruct_dir width).
- MAX_WORDS, 256: maximum number of instructions loaded; must be ≤ 2^ADDR_W.
- END_WORD, 16'hFFFF: terminator word; it ends the load and is never written.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a load session.
- byte_valid, input, 1: byte_data is valid this cycle.
- byte_data, input, 8: incoming program byte.
- byte_ready, output, 1: loader accepts a byte this cycle.
- instruction, output, 16: assembled instruction to instruction memory.
- instruct_dir, output, ADDR_W: write address to instruction memory.
- we, output, 1: one-cycle instruction-memory write strobe.
- finish, output, 1: load complete; level signal.
- busy, output, 1: load session in progress.
- word_count, output, ADDR_W+1: number of instructions written this session.
- overflow, output, 1: session ended by reaching MAX_WORDS, not by END_WORD.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - All outputs 0: instruction, instruct_dir, we, finish, busy, byte_ready, word_count, overflow.
  - Reset wins over every other input in the same cycle, including mid-session; a partially assembled word is discarded.
- Handshake: a byte transfers only in a cycle where byte_valid && byte_ready. byte_ready is high only in HI and LO states, combinationally from state.
- IDLE:
  - start → HI; clear word_count, instruct_dir and overflow; busy = 1.
- HI:
  - On transfer, latch byte_data into hi_byte → LO.
- LO: on transfer, form word = {hi_byte, byte_data}.
  - If word == END_WORD → DONE; no write; overflow stays 0.
  - Otherwise → WRITE; instruction = word.
- WRITE (exactly one cycle):
  - we = 1; instruction and instruct_dir stable for this cycle.
  - Next edge: word_count += 1.
  - If the new word_count == MAX_WORDS → DONE with overflow = 1.
  - Otherwise instruct_dir += 1 → HI.
- DONE:
  - finish = 1, busy = 0, byte_ready = 0; held until reset or start.
  - start in DONE → HI with finish cleared, counters and instruct_dir zeroed, overflow cleared.
- start in HI, LO or WRITE is ignored.
- instruction and instruct_dir are registered and hold their last values outside WRITE.
- we is never high in any state other than WRITE.
- Latency:
  - Second byte accepted at edge N → we high during cycle N+1.
  - Minimum 3 cycles per instruction: HI, LO, WRITE.
- Address wrap: instruct_dir never wraps, because the session terminates at MAX_WORDS.
- Upstream stalls: byte_valid low in HI or LO holds the state indefinitely with no timeout.
- An END_WORD value is only detected on an aligned pair (HI then LO); 8'hFF in HI alone is ordinary data.

Test Plan:
- Reset, start, bytes 12 34 AB CD FF FF → we pulses twice: (dir 0, 16'h1234), (dir 1, 16'hABCD); then finish = 1, word_count = 2, overflow = 0.
- byte_valid toggled randomly during the above stream → identical writes; no byte lost or duplicated; we is never high outside WRITE.
- MAX_WORDS = 4, eight non-terminator bytes streamed → writes to dir 0–3, then finish = 1, overflow = 1, word_count = 4; byte_ready stays 0 afterwards.
- rst_n low for one cycle after byte 56 of a 56 78 pair → state IDLE, all outputs 0; new start plus 9A BC FF FF writes 16'h9ABC at dir 0.
- start pulsed while in LO → ignored; after finish, a second start plus 00 01 FF FF clears finish and writes 16'h0001 at dir 0.
- Stream FF 00 FF FF → 16'hFF00 written at dir 0, then termination with word_count = 1.
